// File: rtl/dice_pkg.sv
// Shared constants for the dice display: digit range, sample counter width and
// the active-high 7-segment patterns.
package dice_pkg;

    localparam int unsigned BIT_CNT_W = 2;

    localparam logic [2:0] DICE_MIN = 3'd1;
    localparam logic [2:0] DICE_MAX = 3'd6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is the blank (post-reset) digit; segments are {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_DIGIT [0:6] = '{
        SEG_BLANK, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D
    };

    function automatic logic [6:0] seg_of(logic [2:0] digit);
        if (digit > DICE_MAX) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[digit];
    endfunction

endpackage

// File: rtl/dice_display_seq_if.sv
// Signal bundle between the divider/shift-register tile, the button and the
// 7-segment display driver.
interface dice_display_seq_if;

    logic       div_tap;
    logic       rnd_bit;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic       upd;
    logic [3:0] rej_cnt;

    modport master (
        output div_tap, rnd_bit, hold,
        input  seg, dp, upd, rej_cnt
    );

    modport slave (
        input  div_tap, rnd_bit, hold,
        output seg, dp, upd, rej_cnt
    );

endinterface

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dice_display_seq.sv
// Assembles 3-bit samples from the asynchronous tap/random bit, rejection-samples
// them to 1..6 and drives a registered 7-segment digit.
module dice_display_seq
    import dice_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input logic                clk,
    input logic                reset,
    dice_display_seq_if.slave  bus
);

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(2);

    logic tap_s, rnd_s, hold_s;
    logic tap_prev_q;
    logic tick;

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]           acc_q, acc_d;
    logic [2:0]           digit_q, digit_d;
    logic [2:0]           cand;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 upd_q, upd_d;
    logic [3:0]           rej_cnt_q, rej_cnt_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_tap (
        .clk   (clk),
        .reset (reset),
        .d     (bus.div_tap),
        .q     (tap_s)
    );

    // Same depth as the tap chain so rnd_s lines up with the tap edge.
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_rnd (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rnd_bit),
        .q     (rnd_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_hold (
        .clk   (clk),
        .reset (reset),
        .d     (bus.hold),
        .q     (hold_s)
    );

    assign tick = tap_s & ~tap_prev_q;
    assign cand = {acc_q, rnd_s};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        digit_d   = digit_q;
        dp_d      = dp_q;
        upd_d     = 1'b0;
        rej_cnt_d = rej_cnt_q;

        if (tick) begin
            if (bit_cnt_q == BIT_CNT_LAST) begin
                bit_cnt_d = '0;
                if (cand >= DICE_MIN && cand <= DICE_MAX) begin
                    // A held display silently drops valid samples.
                    if (!hold_s) begin
                        digit_d = cand;
                        dp_d    = ~dp_q;
                        upd_d   = 1'b1;
                    end
                end else if (rej_cnt_q != 4'hF) begin
                    rej_cnt_d = rej_cnt_q + 4'd1;
                end
            end else begin
                acc_d     = {acc_q[0], rnd_s};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
        end

        // Decode from the next digit so seg changes on the same edge as digit.
        seg_d = seg_of(digit_d) ^ {7{SEG_ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_prev_q <= 1'b0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            digit_q    <= '0;
            seg_q      <= SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
            dp_q       <= SEG_ACTIVE_LOW;
            upd_q      <= 1'b0;
            rej_cnt_q  <= '0;
        end else begin
            tap_prev_q <= tap_s;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            upd_q      <= upd_d;
            rej_cnt_q  <= rej_cnt_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.upd     = upd_q;
    assign bus.rej_cnt = rej_cnt_q;

endmodule

// File: tb/tb_dice_display_seq.sv
// Bench for dice_display_seq: an active-high and an active-low instance share the
// same stimulus and are compared against a sample-level reference model.
module tb_dice_display_seq;

    localparam int unsigned SS = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dice_display_seq_if bus0 ();
    dice_display_seq_if bus1 ();

    assign bus1.div_tap = bus0.div_tap;
    assign bus1.rnd_bit = bus0.rnd_bit;
    assign bus1.hold    = bus0.hold;

    dice_display_seq #(.SYNC_STAGES(SS), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dice_display_seq #(.SYNC_STAGES(SS), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: collected bits of the current sample and the display state.
    bit m_bits [$];
    int m_digit = 0;
    bit m_dp = 1'b0;
    int m_rej = 0;
    int m_upd = 0;
    bit m_hold = 1'b0;

    int upd_seen = 0;
    int upd_run = 0;
    int upd_run_max = 0;

    always @(negedge clk) begin
        if (bus0.upd === 1'b1) begin
            upd_seen++;
            upd_run++;
            if (upd_run > upd_run_max) upd_run_max = upd_run;
        end else begin
            upd_run = 0;
        end
    end

    function automatic logic [6:0] exp_seg(int d);
        case (d)
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_digit = 0;
        m_dp = 1'b0;
        m_rej = 0;
    endtask

    task automatic model_push(bit b);
        int cand;
        m_bits.push_back(b);
        if (m_bits.size() == 3) begin
            cand = 4 * int'(m_bits[0]) + 2 * int'(m_bits[1]) + int'(m_bits[2]);
            m_bits.delete();
            if (cand >= 1 && cand <= 6) begin
                if (!m_hold) begin
                    m_digit = cand;
                    m_dp = ~m_dp;
                    m_upd++;
                end
            end else if (m_rej < 15) begin
                m_rej++;
            end
        end
    endtask

    task automatic tap_tick(bit b);
        @(negedge clk) bus0.rnd_bit = b;
        @(negedge clk) bus0.div_tap = 1'b1;
        repeat (4) @(negedge clk);
        bus0.div_tap = 1'b0;
        repeat (4) @(negedge clk);
        model_push(b);
    endtask

    task automatic set_hold(bit h);
        @(negedge clk) bus0.hold = h;
        m_hold = h;
        repeat (SS + 2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus0.div_tap = 1'b0;
        bus0.rnd_bit = 1'b0;
        bus0.hold = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (bus0.seg !== 7'h00) begin
            errors++; $display("FAIL reset_seg got %h want 00", bus0.seg);
        end
        checks++;
        if (bus1.seg !== 7'h7F) begin
            errors++; $display("FAIL reset_seg_al got %h want 7f", bus1.seg);
        end
        checks++;
        if (bus0.dp !== 1'b0 || bus1.dp !== 1'b1) begin
            errors++; $display("FAIL reset_dp got %b/%b want 0/1", bus0.dp, bus1.dp);
        end
        checks++;
        if (bus0.upd !== 1'b0 || bus0.rej_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_upd_rej got %b/%0d want 0/0", bus0.upd, bus0.rej_cnt);
        end
    endtask

    task automatic test_basic_latency();
        tap_tick(1'b1);
        tap_tick(1'b0);
        @(negedge clk) bus0.rnd_bit = 1'b1;
        @(negedge clk) bus0.div_tap = 1'b1;
        @(posedge clk);   // E0
        @(negedge clk);
        @(posedge clk);   // E0+1
        @(negedge clk);
        checks++;
        if (bus0.seg !== 7'h00 || bus0.upd !== 1'b0) begin
            errors++; $display("FAIL latency_early got seg %h upd %b want 00/0", bus0.seg, bus0.upd);
        end
        @(posedge clk);   // E0+2
        @(negedge clk);
        model_push(1'b1);
        checks++;
        if (bus0.seg !== exp_seg(m_digit) || bus0.seg !== 7'h6D) begin
            errors++; $display("FAIL basic_seg got %h want 6d", bus0.seg);
        end
        checks++;
        if (bus0.upd !== 1'b1 || bus0.dp !== 1'b1) begin
            errors++; $display("FAIL basic_upd_dp got %b/%b want 1/1", bus0.upd, bus0.dp);
        end
        @(negedge clk);
        checks++;
        if (bus0.upd !== 1'b0) begin
            errors++; $display("FAIL basic_upd_width got %b want 0", bus0.upd);
        end
        bus0.div_tap = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturate();
        int upd0 = upd_seen;
        logic [6:0] seg0 = bus0.seg;
        for (int i = 0; i < 20; i++) begin
            tap_tick(1'b1); tap_tick(1'b1); tap_tick(1'b1);
        end
        checks++;
        if (bus0.rej_cnt !== 4'd15 || m_rej != 15) begin
            errors++; $display("FAIL sat_rej got %0d want 15", bus0.rej_cnt);
        end
        checks++;
        if (bus0.seg !== seg0 || upd_seen != upd0) begin
            errors++; $display("FAIL sat_display got seg %h upd %0d want %h/%0d",
                               bus0.seg, upd_seen - upd0, seg0, 0);
        end
    endtask

    task automatic test_hold();
        int upd0 = upd_seen;
        set_hold(1'b1);
        tap_tick(1'b0); tap_tick(1'b1); tap_tick(1'b1);
        checks++;
        if (bus0.seg !== 7'h6D || upd_seen != upd0 || bus0.dp !== m_dp) begin
            errors++; $display("FAIL hold_frozen got seg %h upd %0d dp %b want 6d/0/%b",
                               bus0.seg, upd_seen - upd0, bus0.dp, m_dp);
        end
        set_hold(1'b0);
        tap_tick(1'b0); tap_tick(1'b1); tap_tick(1'b0);
        checks++;
        if (bus0.seg !== 7'h5B || bus1.seg !== ~7'h5B) begin
            errors++; $display("FAIL hold_release got %h/%h want 5b/24", bus0.seg, bus1.seg);
        end
    endtask

    task automatic test_reset_mid_sample();
        tap_tick(1'b1); tap_tick(1'b1);
        pulse_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.seg !== 7'h00 || bus0.rej_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_reset_blank got %h/%0d want 00/0", bus0.seg, bus0.rej_cnt);
        end
        tap_tick(1'b1); tap_tick(1'b1); tap_tick(1'b0);
        checks++;
        if (bus0.seg !== exp_seg(m_digit) || bus0.seg !== 7'h7D || bus0.rej_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_reset_sample got %h/%0d want 7d/0", bus0.seg, bus0.rej_cnt);
        end
    endtask

    task automatic test_held_tap();
        @(negedge clk) bus0.rnd_bit = 1'b0;
        @(negedge clk) bus0.div_tap = 1'b1;
        repeat (1000) @(negedge clk);
        bus0.div_tap = 1'b0;
        repeat (4) @(negedge clk);
        model_push(1'b0);
        tap_tick(1'b0); tap_tick(1'b1);
        checks++;
        if (bus0.seg !== 7'h06) begin
            errors++; $display("FAIL held_tap_seg got %h want 06", bus0.seg);
        end
        checks++;
        if (bus1.seg !== 7'h79 || bus1.dp !== ~m_dp) begin
            errors++; $display("FAIL held_tap_active_low got %h/%b want 79/%b", bus1.seg, bus1.dp, ~m_dp);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            set_hold(1'($urandom_range(0, 3) == 0));
            for (int k = 0; k < 3; k++) tap_tick(1'($urandom_range(0, 1)));
            checks++;
            if (bus0.seg !== exp_seg(m_digit) || bus1.seg !== ~exp_seg(m_digit)) begin
                errors++; $display("FAIL rand_seg[%0d] got %h/%h want %h", s, bus0.seg, bus1.seg,
                                   exp_seg(m_digit));
            end
            checks++;
            if (bus0.dp !== m_dp || bus0.rej_cnt !== 4'(m_rej) || upd_seen != m_upd) begin
                errors++; $display("FAIL rand_state[%0d] got dp %b rej %0d upd %0d want %b/%0d/%0d",
                                   s, bus0.dp, bus0.rej_cnt, upd_seen, m_dp, m_rej, m_upd);
            end
        end
        set_hold(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_saturate();
        test_hold();
        test_reset_mid_sample();
        test_held_tap();
        test_random();
        checks++;
        if (upd_run_max > 1) begin
            errors++; $display("FAIL upd_pulse_width got %0d want 1", upd_run_max);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_display_seq.md
Name: dice_display_seq

Overview:
- Downstream consumer of the ripple-divider/shift-register tile.
- Takes the slow divided tap and the pseudo-random shift-register bit, both asynchronous to the system clock. Synchronizes them and assembles 3-bit samples.
- Rejection-samples the values to 1..6 and drives a registered 7-segment display, with a hold input that freezes the shown value.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer chain (legal range 2..4).
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the output register (common-anode display).

Ports:
- clk  in  1  system clock (all state on rising edge).
- reset  in  1  synchronous, active-high reset.
- div_tap  in  1  divided clock from the ripple divider; asynchronous.
- rnd_bit  in  1  pseudo-random bit from the shift register; asynchronous, stable around div_tap rising edge.
- hold  in  1  freeze request (button); asynchronous, level.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- dp  out  1  decimal point; toggles on every accepted update.
- upd  out  1  one-cycle pulse when the displayed digit changes.
- rej_cnt  out  4  saturating count of rejected samples (0 or 7).

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high; it is sampled only on the clk rising edge.
- Reset values:
  - synchronizer chains, edge register, bit_cnt, acc: 0.
  - digit = 0, meaning blank.
  - seg = all segments off (7'h00, or 7'h7F when SEG_ACTIVE_LOW).
  - dp = off; upd = 0; rej_cnt = 0.
- Synchronizers:
  - div_tap, rnd_bit and hold each pass through a SYNC_STAGES flop chain.
  - tap_prev holds the last synced tap.
  - tick = tap_s & ~tap_prev (internal, one cycle).
  - rnd_s is taken from the same chain depth, so it is the value captured alongside the tap edge.
- Latency: the first clk edge sampling div_tap=1 is edge E0.
  - tick is high in the cycle after edge E0+SYNC_STAGES-1.
  - A resulting digit/seg/upd change is visible after edge E0+SYNC_STAGES.
- Sample assembly (bit_cnt 0..2):
  - On tick with bit_cnt<2: acc <= {acc[0], rnd_s}; bit_cnt++.
  - On tick with bit_cnt==2: cand = {acc[1:0], rnd_s}; bit_cnt <= 0. cand is evaluated as below.
- Evaluating cand:
  - cand in 1..6 and hold_s==0: digit <= cand, dp toggles, upd pulses for 1 cycle.
  - cand in 1..6 and hold_s==1: sample dropped silently. No upd, digit and dp unchanged, rej_cnt unchanged.
  - cand 0 or 7: rejected. rej_cnt increments, saturating at 15. Applies regardless of hold.
- Segment decode (active-high, registered from digit):
  - 0 blank 7'h00
  - 1 7'h06
  - 2 7'h5B
  - 3 7'h4F
  - 4 7'h66
  - 5 7'h6D
  - 6 7'h7D
- SEG_ACTIVE_LOW inverts both seg and dp.
- Boundaries:
  - div_tap held high: exactly one tick. No further ticks until tap_s falls and rises again.
  - Tap glitch shorter than one clk: may be missed, never produces two ticks.
  - Reset mid-sample: partial acc and bit_cnt are discarded, display blanks, and the next three ticks form a fresh sample.
  - Reset asserted in the same cycle as tick: reset wins, and no update occurs.
  - hold change coincident with tick: the value of hold_s in that cycle decides.

Decomposition:
- Shared package dice_pkg holds:
  - SEG_BLANK and the SEG_DIGIT[0:6] constant array.
  - DICE_MIN=1, DICE_MAX=6.
  - the bit_cnt width.
- One sub-module sync_chain: parameter STAGES, 1-bit, synchronous reset to 0. Instantiated three times.

Test Plan:
- Reset, then 10 idle cycles -> seg=7'h00, dp=0, upd=0, rej_cnt=0.
- Three div_tap rising edges with rnd_bit=1,0,1 -> cand=5. After the third edge + SYNC_STAGES edges: seg=7'h6D, dp=1, upd high for exactly 1 cycle.
- Three ticks with rnd_bit=1,1,1 (cand=7), sequence repeated 20 times -> seg unchanged, rej_cnt saturates at 15, upd never asserted.
- hold=1 during a sample 0,1,1 (cand=3) -> digit unchanged, no upd. Release hold, then sample 0,1,0 -> seg=7'h5B.
- Reset pulsed after 2 of 3 ticks, then sample 1,1,0 -> seg=7'h7D (6). The pre-reset bits have no effect.
- div_tap held high for 1000 clk -> exactly one tick counted (bit_cnt advances by 1). With SEG_ACTIVE_LOW=1 and digit 1 -> seg=7'h79.
